add4_sweep_ctrl: RTL and testbench

//   Sequencer for the four-operand adder datapath (add4). On start, walks all
//   2^(4*W) operand combinations through an external add4 instance and checks
//   {ov,sum} against an internal golden sum. Counts errors and captures the

---
 rtl/add4_sweep_ctrl.sv | 111 +++++++++++
 tb/tb_add4_sweep_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/add4_sweep_ctrl.sv
// rtl/add4_sweep_ctrl.sv - exhaustive self-test sequencer for the add4 adder datapath
module add4_sweep_ctrl #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b,
    output logic [W-1:0]   op_c,
    output logic [W-1:0]   op_d,
    input  logic [W:0]     dut_sum,
    input  logic           dut_ov,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [4*W-1:0] test_num,
    output logic [4*W:0]   err_cnt,
    output logic           fail_vld,
    output logic [4*W-1:0] fail_vec,
    output logic [W+1:0]   fail_got
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t       state;
    state_t       state_nx;
    logic [3:0]   settle_cnt;
    logic [W+1:0] gold;
    logic [W+1:0] got;
    logic         mismatch;
    logic         last_vec;
    logic         launch;

    // Operands come straight from the vector index, a in the low bits.
    assign {op_d, op_c, op_b, op_a} = test_num;

    assign gold     = {2'b00, op_a} + {2'b00, op_b} + {2'b00, op_c} + {2'b00, op_d};
    assign got      = {dut_ov, dut_sum};
    assign mismatch = (got != gold);
    assign last_vec = &test_num;
    assign launch   = start && !abort && (state == S_IDLE || state == S_DONE);

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nx = S_WAIT;
                S_DONE:  if (start) state_nx = S_WAIT;
                S_WAIT:  if (settle_cnt == SETTLE_LAST) state_nx = S_CHECK;
                S_CHECK: state_nx = last_vec ? S_DONE : S_WAIT;
                default: state_nx = S_IDLE;
            endcase
        end
        busy = (state == S_WAIT) || (state == S_CHECK);
        done = (state == S_DONE);
    end

    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            test_num   <= '0;
            err_cnt    <= '0;
            fail_vld   <= 1'b0;
            fail_vec   <= '0;
            fail_got   <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                settle_cnt <= '0;
                test_num   <= '0;
                err_cnt    <= '0;
                fail_vld   <= 1'b0;
                fail_vec   <= '0;
                fail_got   <= '0;
            end else if (abort) begin
                // Results are left in place for inspection; only the settle timer restarts.
                settle_cnt <= '0;
            end else begin
                if (state == S_WAIT) begin
                    settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
                end
                if (state == S_CHECK) begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!fail_vld) begin
                            fail_vld <= 1'b1;
                            fail_vec <= test_num;
                            fail_got <= got;
                        end
                    end
                    if (!last_vec) begin
                        test_num <= test_num + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_add4_sweep_ctrl.sv
// tb/tb_add4_sweep_ctrl.sv - directed self-checking bench for add4_sweep_ctrl
module tb_add4_sweep_ctrl;

    localparam int W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, abort, start3, fault;
    logic [W-1:0]   op_a, op_b, op_c, op_d;
    logic [W:0]     dut_sum;
    logic           dut_ov, busy, done, pass, fail_vld;
    logic [4*W-1:0] test_num, fail_vec;
    logic [4*W:0]   err_cnt;
    logic [W+1:0]   fail_got;
    logic [W+1:0]   tot;

    logic [W-1:0]   op3_a, op3_b, op3_c, op3_d;
    logic [W:0]     sum3;
    logic           ov3, busy3, done3, pass3, fail_vld3;
    logic [4*W-1:0] test_num3, fail_vec3;
    logic [4*W:0]   err_cnt3;
    logic [W+1:0]   fail_got3;
    logic [W+1:0]   p1, p2, p3;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;
    int exp_err;

    add4_sweep_ctrl #(.W(W), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
        .dut_sum(dut_sum), .dut_ov(dut_ov),
        .busy(busy), .done(done), .pass(pass), .test_num(test_num),
        .err_cnt(err_cnt), .fail_vld(fail_vld), .fail_vec(fail_vec), .fail_got(fail_got)
    );

    add4_sweep_ctrl #(.W(W), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort),
        .op_a(op3_a), .op_b(op3_b), .op_c(op3_c), .op_d(op3_d),
        .dut_sum(sum3), .dut_ov(ov3),
        .busy(busy3), .done(done3), .pass(pass3), .test_num(test_num3),
        .err_cnt(err_cnt3), .fail_vld(fail_vld3), .fail_vec(fail_vec3), .fail_got(fail_got3)
    );

    // Adder model; fault forces ov low.
    assign tot     = {2'b00, op_a} + {2'b00, op_b} + {2'b00, op_c} + {2'b00, op_d};
    assign dut_sum = tot[W:0];
    assign dut_ov  = fault ? 1'b0 : tot[W+1];

    // Slow adder: result appears three clocks after its operands.
    always @(posedge clk) begin
        p1 <= {2'b00, op3_a} + {2'b00, op3_b} + {2'b00, op3_c} + {2'b00, op3_d};
        p2 <= p1;
        p3 <= p2;
    end
    assign sum3 = p3[W:0];
    assign ov3  = p3[W+1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit slow, input int limit, output int n);
        n = 0;
        while (n < limit && !(slow ? done3 : done)) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0; fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {busy, done, pass, fail_vld, test_num, err_cnt}, 0);
        check("rst_ops", {op_d, op_c, op_b, op_a}, 0);
        @(negedge clk) rst = 1'b0;

        // Reset mid-sweep after a failure has been captured.
        fault = 1'b1;
        pulse_start();
        repeat (500) @(posedge clk);
        #1 check("mid_fail_vld", fail_vld, 1);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_state", {busy, done, pass, fail_vld}, 0);
        check("rst_mid_cnt", {test_num, err_cnt, fail_vec, fail_got}, 0);
        @(negedge clk) begin rst = 1'b0; fault = 1'b0; end

        // Clean full sweep: 2^12 vectors at two cycles each.
        pulse_start();
        check("restart_num", test_num, 0);
        check("restart_busy", busy, 1);
        wait_done(1'b0, 9000, cycles);
        check("sweep_cycles", cycles, 8192);
        check("clean_result", {done, pass, busy, fail_vld}, 4'b1100);
        check("clean_err", err_cnt, 0);
        check("last_num", test_num, 12'hFFF);
        repeat (3) @(posedge clk);
        #1 check("done_held", {done, test_num}, {1'b1, 12'hFFF});

        // ov stuck low: first miss at c=2,b=7,a=7 (2+7+7=16).
        exp_err = 0;
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 8; c++)
                    for (int d = 0; d < 8; d++)
                        if (a + b + c + d >= 16) exp_err++;
        fault = 1'b1;
        pulse_start();
        check("rerun_clears_done", {done, busy}, 2'b01);
        wait_done(1'b0, 9000, cycles);
        check("fault_done", done, 1);
        check("fault_pass", pass, 0);
        check("fault_err", err_cnt, exp_err);
        check("fault_vld", fail_vld, 1);
        check("fault_vec", fail_vec, 12'h0BF);
        check("fault_got", fail_got, 0);
        fault = 1'b0;

        // Abort at vector 100.
        pulse_start();
        cycles = 0;
        while (cycles < 1000 && test_num != 12'd100) begin
            @(negedge clk);
            cycles++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_state", {busy, done, pass}, 0);
        check("abort_num", test_num, 100);
        repeat (2) @(posedge clk);
        #1 check("abort_hold", {busy, test_num}, {1'b0, 12'd100});

        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        check("abort_wins", {busy, test_num}, {1'b0, 12'd100});

        pulse_start();
        check("abort_restart", {busy, test_num, err_cnt}, {1'b1, 12'd0, 13'd0});

        // Start while busy is ignored.
        cycles = 0;
        while (cycles < 100 && test_num != 12'd10) begin
            @(negedge clk);
            cycles++;
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_start_num", {busy, test_num}, {1'b1, 12'd10});
        @(posedge clk);
        #1 check("busy_start_next", test_num, 11);
        wait_done(1'b0, 9000, cycles);
        check("busy_start_pass", {done, pass}, 2'b11);

        // Slow adder with SETTLE=3: no false errors, four cycles per vector.
        @(negedge clk) start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        wait_done(1'b1, 17000, cycles);
        check("slow_cycles", cycles, 16384);
        check("slow_pass", {done3, pass3, fail_vld3}, 3'b110);
        check("slow_err", err_cnt3, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
